alu_param: RTL and testbench

Parametrised, handshaked successor to the single-cycle 32-bit `alu`. It keeps the existing opcode encoding and Z/C/V flag semantics. It adds:
- a configurable datapath width;
- barrel shifts;
- an optional iterative multiplier;
- valid/ready flow control on both sides, with a one-entry registered output stage.

It sits between the decode stage and writeback in the next-generation datapath.

---
 rtl/alu_param_if.sv | 28 ++
 rtl/alu_param.sv | 180 ++++++++++++++++++
 tb/tb_alu_param.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_param_if.sv
// Operand/result handshake bundle for alu_param.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, src1, src2, ALU_control, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow, illegal
  );

  modport slave (
    input  in_valid, src1, src2, ALU_control, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow, illegal
  );
endinterface

// File: rtl/alu_param.sv
// Parametrised handshaked ALU with a one-entry registered output stage.
// Define ALU_MUL_EN to add the iterative shift-add multiplier on opcode 8.
module alu_param #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  alu_param_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH:0]   diff_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] op_result;
  logic             op_cout;
  logic             op_ovf;
  logic             op_illegal;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_value;
  logic             load;
  logic [WIDTH-1:0] load_result;
  logic             load_cout;
  logic             load_ovf;
  logic             load_illegal;

  assign shamt     = bus.src2[SW-1:0];
  assign sum_full  = {1'b0, bus.src1} + {1'b0, bus.src2};
  assign diff_full = {1'b0, bus.src1} + {1'b0, ~bus.src2} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf   = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (sum_full[WIDTH-1] != bus.src1[WIDTH-1]);
  assign sub_ovf   = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (diff_full[WIDTH-1] != bus.src1[WIDTH-1]);
  // Overflow-corrected sign of the difference gives the signed compare.
  assign slt_bit   = diff_full[WIDTH-1] ^ sub_ovf;

  always_comb begin
    op_result  = '0;
    op_cout    = 1'b0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    case (bus.ALU_control)
      OP_AND: op_result = bus.src1 & bus.src2;
      OP_OR:  op_result = bus.src1 | bus.src2;
      OP_NOR: op_result = ~(bus.src1 | bus.src2);
      OP_ADD: begin
        op_result = sum_full[WIDTH-1:0];
        op_cout   = sum_full[WIDTH];
        op_ovf    = add_ovf;
      end
      OP_SUB: begin
        op_result = diff_full[WIDTH-1:0];
        op_cout   = diff_full[WIDTH];
        op_ovf    = sub_ovf;
      end
      OP_SLT: op_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL: op_result = bus.src1 << shamt;
      OP_SRL: op_result = bus.src1 >> shamt;
      OP_SRA: op_result = $unsigned($signed(bus.src1) >>> shamt);
      default: op_illegal = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
  localparam logic [3:0]    OP_MUL    = 4'd8;
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  state_t           state_next;
  logic [SW-1:0]    step_cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             mul_active;

  assign is_mul = (bus.ALU_control == OP_MUL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mul) state_next = MUL;
      MUL:     if (step_cnt == LAST_STEP) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_active   = (state == MUL);
    mul_done     = mul_active && (step_cnt == LAST_STEP);
    bus.in_ready = rst_n && (state == IDLE) && (!bus.out_valid || bus.out_ready);
  end

  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign mul_value = acc_next;

  // One shift-add step per MUL cycle; the final step feeds the output stage directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else if (accept && is_mul) begin
      step_cnt <= '0;
      mcand    <= bus.src1;
      mplier   <= bus.src2;
      acc      <= '0;
    end else if (mul_active) begin
      step_cnt <= step_cnt + SW'(1);
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      acc      <= acc_next;
    end
  end
`else
  assign is_mul       = 1'b0;
  assign mul_done     = 1'b0;
  assign mul_value    = '0;
  assign bus.in_ready = rst_n && (!bus.out_valid || bus.out_ready);
`endif

  assign load = (accept && !is_mul) || mul_done;

  always_comb begin
    load_result  = op_result;
    load_cout    = op_cout;
    load_ovf     = op_ovf;
    load_illegal = op_illegal;
    if (mul_done) begin
      load_result  = mul_value;
      load_cout    = 1'b0;
      load_ovf     = 1'b0;
      load_illegal = 1'b0;
    end
  end

  // A load on the consuming edge wins, so back-to-back results keep out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.cout      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.illegal   <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.result    <= load_result;
      bus.zero      <= (load_result == '0);
      bus.cout      <= load_cout;
      bus.overflow  <= load_ovf;
      bus.illegal   <= load_illegal;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_param.sv
// Directed self-checking bench for alu_param (WIDTH = 32); the multiply
// scenario follows whether ALU_MUL_EN is defined.
module tb_alu_param;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_param_if #(.WIDTH(WIDTH)) bus_if ();

  alu_param #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.in_valid    = 1'b1;
    bus_if.ALU_control = op;
    bus_if.src1        = a;
    bus_if.src2        = b;
  endtask

  task automatic idle_inputs();
    bus_if.in_valid    = 1'b0;
    bus_if.ALU_control = 4'd0;
    bus_if.src1        = '0;
    bus_if.src2        = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus_if.out_ready = 1'b1;
    tick();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus_if.in_ready);
    end
    checks++;
    if ({bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.illegal} !== 36'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got result %h zcvi %b%b%b%b expected all 0",
                         bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.illegal);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus_if.in_ready);
    end
  endtask

  task automatic test_arith();
    drive(4'd2, 32'h7FFFFFFF, 32'h00000001);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.result !== 32'h80000000) begin
      errors++; $display("[TB] FAIL add_result: got valid %b result %h expected 1 80000000", bus_if.out_valid, bus_if.result);
    end
    checks++;
    if ({bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.illegal} !== 4'b0010) begin
      errors++; $display("[TB] FAIL add_flags: got zcvi %b%b%b%b expected 0010", bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.illegal);
    end
    drive(4'd6, 32'h00000005, 32'h00000005);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h0 || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b110) begin
      errors++; $display("[TB] FAIL sub_equal: got %h zcv %b%b%b expected 00000000 110", bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow);
    end
    drive(4'd6, 32'h00000000, 32'h00000001);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'hFFFFFFFF || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b000) begin
      errors++; $display("[TB] FAIL sub_borrow: got %h zcv %b%b%b expected ffffffff 000", bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow);
    end
  endtask

  task automatic test_slt();
    drive(4'd7, 32'h80000000, 32'h00000001);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h1 || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b000) begin
      errors++; $display("[TB] FAIL slt_neg_lt_pos: got %h zcv %b%b%b expected 00000001 000", bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow);
    end
    drive(4'd7, 32'h7FFFFFFF, 32'h80000000);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h0 || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b100) begin
      errors++; $display("[TB] FAIL slt_ovf_corrected: got %h zcv %b%b%b expected 00000000 100", bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow);
    end
  endtask

  task automatic test_illegal();
    drive(4'd9, 32'h12345678, 32'h9ABCDEF0);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h0 || {bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.illegal} !== 4'b1001) begin
      errors++; $display("[TB] FAIL illegal_op9: got %h zcvi %b%b%b%b expected 00000000 1001",
                         bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.illegal);
    end
    drive(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.illegal !== 1'b1 || bus_if.result !== 32'h0) begin
      errors++; $display("[TB] FAIL illegal_op15: got valid %b illegal %b result %h expected 1 1 00000000",
                         bus_if.out_valid, bus_if.illegal, bus_if.result);
    end
  endtask

  task automatic test_logic();
    drive(4'd12, 32'h0F0F0000, 32'h00000F0F);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'hF0F0F0F0 || bus_if.zero !== 1'b0 || bus_if.illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL nor_result: got %h z %b i %b expected f0f0f0f0 0 0", bus_if.result, bus_if.zero, bus_if.illegal);
    end
    drive(4'd12, 32'hFFFFFFFF, 32'h00000000);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h0 || bus_if.zero !== 1'b1) begin
      errors++; $display("[TB] FAIL nor_zero: got %h z %b expected 00000000 1", bus_if.result, bus_if.zero);
    end
  endtask

  task automatic test_shift();
    drive(4'd5, 32'h80000000, 32'h00000004);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'hF8000000) begin
      errors++; $display("[TB] FAIL sra_neg: got %h expected f8000000", bus_if.result);
    end
    drive(4'd4, 32'h80000000, 32'h00000004);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h08000000) begin
      errors++; $display("[TB] FAIL srl: got %h expected 08000000", bus_if.result);
    end
    drive(4'd3, 32'h00000001, 32'h00000025);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h00000020 || {bus_if.cout, bus_if.overflow} !== 2'b00) begin
      errors++; $display("[TB] FAIL sll_wrap: got %h cv %b%b expected 00000020 00", bus_if.result, bus_if.cout, bus_if.overflow);
    end
    drive(4'd5, 32'h40000000, 32'h00000021);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h20000000) begin
      errors++; $display("[TB] FAIL sra_pos_wrap: got %h expected 20000000", bus_if.result);
    end
  endtask

  task automatic test_back_to_back();
    drive(4'd2, 32'h00000001, 32'h00000002);
    tick();
    checks++;
    if (bus_if.result !== 32'h3 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_first: got %h ready %b expected 00000003 1", bus_if.result, bus_if.in_ready);
    end
    drive(4'd6, 32'h0000000A, 32'h00000003);
    tick();
    checks++;
    if (bus_if.result !== 32'h7 || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b010 || bus_if.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_second: got %h zcv %b%b%b valid %b expected 00000007 010 1",
                         bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.out_valid);
    end
    drive(4'd2, 32'hFFFFFFFF, 32'h00000001);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h0 || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b110) begin
      errors++; $display("[TB] FAIL b2b_third: got %h zcv %b%b%b expected 00000000 110", bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow);
    end
    tick();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_drain: got valid %b expected 0", bus_if.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus_if.out_ready = 1'b0;
    drive(4'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    drive(4'd2, 32'h00000001, 32'h00000001);
    tick();
    tick();
    checks++;
    if (bus_if.result !== 32'hF000F000 || bus_if.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_hold: got %h valid %b expected f000f000 1", bus_if.result, bus_if.out_valid);
    end
    checks++;
    if (bus_if.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_in_ready: got %b expected 0", bus_if.in_ready);
    end
    drive(4'd1, 32'h0000000F, 32'h000000F0);
    bus_if.out_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus_if.in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus_if.result !== 32'h000000FF || bus_if.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL replace_on_consume: got %h valid %b expected 000000ff 1", bus_if.result, bus_if.out_valid);
    end
    tick();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL consume_clears: got valid %b expected 0", bus_if.out_valid);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int early;
    bus_if.out_ready = 1'b1;
    drive(4'd8, 32'h00010000, 32'h00010001);
    tick();
    idle_inputs();
    early = 0;
    for (int k = 1; k < WIDTH; k++) begin
      if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0) early++;
      tick();
    end
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0) early++;
    checks++;
    if (early != 0) begin
      errors++; $display("[TB] FAIL mul_busy: got %0d cycles with valid or ready high expected 0", early);
    end
    tick();
    checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.result !== 32'h00010000 || bus_if.illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL mul_result: got valid %b result %h illegal %b expected 1 00010000 0",
                         bus_if.out_valid, bus_if.result, bus_if.illegal);
    end
    drive(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    idle_inputs();
    for (int k = 1; k < WIDTH; k++) tick();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mul2_early: got valid %b expected 0", bus_if.out_valid);
    end
    tick();
    checks++;
    if (bus_if.result !== 32'h00000001 || {bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b000) begin
      errors++; $display("[TB] FAIL mul2_result: got %h zcv %b%b%b expected 00000001 000", bus_if.result, bus_if.zero, bus_if.cout, bus_if.overflow);
    end
    drive(4'd8, 32'h00000003, 32'h00000004);
    tick();
    idle_inputs();
    for (int k = 1; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mul_reset_ready: got %b expected 1", bus_if.in_ready);
    end
    early = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_if.out_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("[TB] FAIL mul_reset_abort: got %0d cycles with out_valid high expected 0", early);
    end
  endtask
`else
  task automatic test_mul();
    bus_if.out_ready = 1'b1;
    drive(4'd8, 32'h00010000, 32'h00010001);
    tick();
    idle_inputs();
    checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.illegal !== 1'b1 || bus_if.result !== 32'h0) begin
      errors++; $display("[TB] FAIL mul_disabled: got valid %b illegal %b result %h expected 1 1 00000000",
                         bus_if.out_valid, bus_if.illegal, bus_if.result);
    end
    checks++;
    if ({bus_if.zero, bus_if.cout, bus_if.overflow} !== 3'b100 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mul_disabled_flags: got zcv %b%b%b ready %b expected 100 1",
                         bus_if.zero, bus_if.cout, bus_if.overflow, bus_if.in_ready);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting alu_param bench");
    test_reset();
    test_arith();
    test_slt();
    test_illegal();
    test_logic();
    test_shift();
    test_back_to_back();
    test_backpressure();
    test_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
